// File: rtl/scpu_byte_mem_resp.sv
// Byte-serial front end for a 16-bit synchronous word memory. It serves one fetch port and one data port,
// each with a one-deep pending slot. Data requests take priority over fetches.
module scpu_byte_mem_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [8:0]  i_addr,
    output logic [7:0]  i_datain,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [8:0]  d_addr,
    input  logic [7:0]  d_dataout,
    output logic [7:0]  d_datain,
    output logic        d_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        ovf
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_LO, RD_HI, WR_HI, WR_COMMIT} state_t;

    state_t      r_state;
    logic        r_ip_v, r_dp_v, r_dp_we;
    logic [8:0]  r_ip_addr, r_dp_addr, r_waddr;
    logic [7:0]  r_dp_lo, r_dp_hi, r_wlo, r_whi, r_word_hi;
    logic        r_act_d, r_hi_due, r_hi_to_slot;

    logic        w_can_start, w_start_d, w_start_i, w_d_direct, w_i_direct;
    logic        w_d_keep, w_i_keep, w_d_drop, w_i_drop, w_slot_hi_live;
    logic        w_s_we;
    logic [8:0]  w_s_daddr, w_s_iaddr;
    logic [7:0]  w_s_lo, w_s_hi, w_hi_now;

    always_comb begin
        w_can_start    = (r_state == IDLE) || (r_state == RD_HI) || (r_state == WR_COMMIT);
        w_start_d      = w_can_start && (r_dp_v || d_req);
        w_start_i      = w_can_start && !(r_dp_v || d_req) && (r_ip_v || i_req);
        w_d_direct     = w_start_d && !r_dp_v;
        w_i_direct     = w_start_i && !r_ip_v;
        // A full slot frees up on the same edge it is started, so it can take a new request then.
        w_d_keep       = d_req && !w_d_direct && (!r_dp_v || w_start_d);
        w_i_keep       = i_req && !w_i_direct && (!r_ip_v || w_start_i);
        w_d_drop       = d_req && !w_d_direct && r_dp_v && !w_start_d;
        w_i_drop       = i_req && !w_i_direct && r_ip_v && !w_start_i;
        w_s_we         = r_dp_v ? r_dp_we   : d_we;
        w_s_daddr      = r_dp_v ? r_dp_addr : d_addr;
        w_s_lo         = r_dp_v ? r_dp_lo   : d_dataout;
        w_s_iaddr      = r_ip_v ? r_ip_addr : i_addr;
        // The high byte of a write is always on d_dataout one edge after its d_req.
        w_slot_hi_live = r_hi_due && r_hi_to_slot;
        w_s_hi         = w_slot_hi_live ? d_dataout : r_dp_hi;
        w_hi_now       = (r_hi_due && !r_hi_to_slot) ? d_dataout : r_whi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ip_v       <= 1'b0;
            r_ip_addr    <= '0;
            r_dp_v       <= 1'b0;
            r_dp_we      <= 1'b0;
            r_dp_addr    <= '0;
            r_dp_lo      <= '0;
            r_dp_hi      <= '0;
            r_waddr      <= '0;
            r_wlo        <= '0;
            r_whi        <= '0;
            r_word_hi    <= '0;
            r_act_d      <= 1'b0;
            r_hi_due     <= 1'b0;
            r_hi_to_slot <= 1'b0;
            i_datain     <= '0;
            i_valid      <= 1'b0;
            d_datain     <= '0;
            d_valid      <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_valid   <= 1'b0;
            i_datain  <= '0;
            d_valid   <= 1'b0;
            d_datain  <= '0;

            if (w_start_d && r_dp_v) r_dp_v <= 1'b0;
            if (w_d_keep) begin
                r_dp_v    <= 1'b1;
                r_dp_we   <= d_we;
                r_dp_addr <= d_addr;
                r_dp_lo   <= d_dataout;
            end
            if (w_slot_hi_live) r_dp_hi <= d_dataout;
            if (w_start_i && r_ip_v) r_ip_v <= 1'b0;
            if (w_i_keep) begin
                r_ip_v    <= 1'b1;
                r_ip_addr <= i_addr;
            end
            if (w_d_drop || w_i_drop) ovf <= 1'b1;
            r_hi_due     <= d_req && d_we && (w_d_direct || w_d_keep);
            r_hi_to_slot <= !w_d_direct;

            case (r_state)
                RD_ISSUE: begin
                    r_state <= RD_WAIT;
                    busy    <= 1'b1;
                end
                RD_WAIT: begin
                    r_state   <= RD_LO;
                    busy      <= 1'b1;
                    r_word_hi <= mem_rdata[15:8];
                    if (r_act_d) begin
                        d_valid  <= 1'b1;
                        d_datain <= mem_rdata[7:0];
                    end else begin
                        i_valid  <= 1'b1;
                        i_datain <= mem_rdata[7:0];
                    end
                end
                RD_LO: begin
                    r_state <= RD_HI;
                    busy    <= 1'b1;
                    if (r_act_d) begin
                        d_valid  <= 1'b1;
                        d_datain <= r_word_hi;
                    end else begin
                        i_valid  <= 1'b1;
                        i_datain <= r_word_hi;
                    end
                end
                WR_HI: begin
                    r_state   <= WR_COMMIT;
                    busy      <= 1'b1;
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= r_waddr;
                    mem_wdata <= {w_hi_now, r_wlo};
                    d_valid   <= 1'b1;
                end
                default: begin
                    // IDLE, RD_HI and WR_COMMIT all chain straight into the next request.
                    busy <= w_start_d || w_start_i;
                    if (w_start_d) begin
                        r_act_d <= 1'b1;
                        r_waddr <= w_s_daddr;
                        if (w_s_we) begin
                            r_state <= WR_HI;
                            r_wlo   <= w_s_lo;
                            r_whi   <= w_s_hi;
                        end else begin
                            r_state  <= RD_ISSUE;
                            mem_en   <= 1'b1;
                            mem_addr <= w_s_daddr;
                        end
                    end else if (w_start_i) begin
                        r_act_d  <= 1'b0;
                        r_state  <= RD_ISSUE;
                        mem_en   <= 1'b1;
                        mem_addr <= w_s_iaddr;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scpu_byte_mem_resp.sv
// Randomized and directed check of scpu_byte_mem_resp against a transaction-level model
// (shadow word memory plus per-operation durations).
module tb_scpu_byte_mem_resp;
    logic        clk, rst_n;
    logic        i_req, d_req, d_we;
    logic [8:0]  i_addr, d_addr, mem_addr;
    logic [7:0]  i_datain, d_datain, d_dataout;
    logic        i_valid, d_valid, mem_en, mem_we, busy, ovf;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [512];
    logic [15:0] ref_mem [512];
    int n_chk = 0, n_err = 0;

    scpu_byte_mem_resp dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_datain(i_datain), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_dataout(d_dataout),
        .d_datain(d_datain), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read word memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " i_valid"}, 32'(i_valid), 0);
        chk({tag, " i_datain"}, 32'(i_datain), 0);
        chk({tag, " d_valid"}, 32'(d_valid), 0);
        chk({tag, " d_datain"}, 32'(d_datain), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " ovf"}, 32'(ovf), 0);
    endtask

    // One fetch and/or one data op issued in the same cycle from idle; data is served first, fetch
    // follows with no gap. A read lasts 4 cycles (bytes in its 3rd and 4th), a write 2 (commit in its 2nd).
    task automatic run_op(input bit di, input bit dd, input bit dwe, input logic [8:0] ia,
                          input logic [8:0] da, input logic [7:0] lo, input logic [7:0] hi,
                          input bit rel, input bit eovf, input string tag);
        logic       e_iv [10], e_dv [10], e_me [10], e_mw [10];
        logic [7:0] e_id [10], e_dd [10];
        logic [8:0] e_ma [10];
        logic [15:0] e_wd [10], w;
        int off = 0;
        for (int k = 0; k < 10; k++) begin
            e_iv[k] = 0; e_dv[k] = 0; e_me[k] = 0; e_mw[k] = 0;
            e_id[k] = 0; e_dd[k] = 0; e_ma[k] = 0; e_wd[k] = 0;
        end
        if (dd) begin
            if (dwe) begin
                e_me[off+1] = 1; e_mw[off+1] = 1; e_ma[off+1] = da; e_wd[off+1] = {hi, lo};
                e_dv[off+1] = 1;
                ref_mem[da] = {hi, lo};
                off += 2;
            end else begin
                w = ref_mem[da];
                e_me[off] = 1; e_ma[off] = da;
                e_dv[off+2] = 1; e_dd[off+2] = w[7:0];
                e_dv[off+3] = 1; e_dd[off+3] = w[15:8];
                off += 4;
            end
        end
        if (di) begin
            w = ref_mem[ia];
            e_me[off] = 1; e_ma[off] = ia;
            e_iv[off+2] = 1; e_id[off+2] = w[7:0];
            e_iv[off+3] = 1; e_id[off+3] = w[15:8];
            off += 4;
        end
        @(negedge clk);
        if (rel) rst_n = 1;
        i_req = di; i_addr = ia; d_req = dd; d_we = dwe; d_addr = da; d_dataout = lo;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("%s s%0d i_valid", tag, k), 32'(i_valid), 32'(e_iv[k]));
            chk($sformatf("%s s%0d i_datain", tag, k), 32'(i_datain), 32'(e_id[k]));
            chk($sformatf("%s s%0d d_valid", tag, k), 32'(d_valid), 32'(e_dv[k]));
            chk($sformatf("%s s%0d d_datain", tag, k), 32'(d_datain), 32'(e_dd[k]));
            chk($sformatf("%s s%0d mem_en", tag, k), 32'(mem_en), 32'(e_me[k]));
            chk($sformatf("%s s%0d mem_we", tag, k), 32'(mem_we), 32'(e_mw[k]));
            if (e_me[k]) chk($sformatf("%s s%0d mem_addr", tag, k), 32'(mem_addr), 32'(e_ma[k]));
            if (e_mw[k]) chk($sformatf("%s s%0d mem_wdata", tag, k), 32'(mem_wdata), 32'(e_wd[k]));
            chk($sformatf("%s s%0d busy", tag, k), 32'(busy), 32'(k < off));
            chk($sformatf("%s s%0d ovf", tag, k), 32'(ovf), 32'(eovf));
            @(negedge clk);
            if (k == 0) begin
                i_req = 0; d_req = 0; d_dataout = hi;
                i_addr = 9'($urandom); d_addr = 9'($urandom); d_we = 1'($urandom);
            end else begin
                d_dataout = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        clk = 0; rst_n = 0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_dataout = 0;
        for (int a = 0; a < 512; a++) begin
            w = 16'($urandom);
            mem[a] = w; ref_mem[a] = w;
        end
        mem[0] = 16'h8A10; ref_mem[0] = 16'h8A10;
        mem[1] = 16'h3C00; ref_mem[1] = 16'h3C00;
        #12;
        chk_all_zero("reset");

        // Release and fetch on the very first edge.
        run_op(1, 0, 0, 9'h000, 9'h000, 8'h00, 8'h00, 1, 0, "fetch0");
        run_op(0, 1, 1, 9'h000, 9'h002, 8'hAB, 8'h3C, 0, 0, "write2");
        run_op(1, 1, 0, 9'h002, 9'h001, 8'h00, 8'h00, 0, 0, "simul");
        run_op(1, 1, 1, 9'h002, 9'h003, 8'h5A, 8'hC3, 0, 0, "simulw");

        for (int n = 0; n < 40; n++) begin
            bit di, dd;
            di = 1'($urandom); dd = 1'($urandom);
            if (!di && !dd) dd = 1;
            run_op(di, dd, 1'($urandom), 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
                   8'($urandom), 8'($urandom), 0, 0, $sformatf("rnd%0d", n));
        end

        // Two data reads during one fetch: the first waits in the slot, the second is dropped.
        @(negedge clk); i_req = 1; i_addr = 9'h005;
        tick(); chk("ovf s0 mem_en", 32'(mem_en), 1); chk("ovf s0 mem_addr", 32'(mem_addr), 5);
        @(negedge clk); i_req = 0; d_req = 1; d_we = 0; d_addr = 9'h007;
        tick(); chk("ovf s1 ovf", 32'(ovf), 0);
        @(negedge clk); d_req = 0;
        tick(); chk("ovf s2 i_valid", 32'(i_valid), 1); chk("ovf s2 i_datain", 32'(i_datain), 32'(ref_mem[5][7:0]));
        @(negedge clk); d_req = 1; d_addr = 9'h009;
        tick(); chk("ovf s3 i_datain", 32'(i_datain), 32'(ref_mem[5][15:8])); chk("ovf s3 ovf", 32'(ovf), 1);
        @(negedge clk); d_req = 0;
        tick(); chk("ovf s4 mem_en", 32'(mem_en), 1); chk("ovf s4 mem_addr", 32'(mem_addr), 7);
        tick(); chk("ovf s5 d_valid", 32'(d_valid), 0);
        tick(); chk("ovf s6 d_valid", 32'(d_valid), 1); chk("ovf s6 d_datain", 32'(d_datain), 32'(ref_mem[7][7:0]));
        tick(); chk("ovf s7 d_valid", 32'(d_valid), 1); chk("ovf s7 d_datain", 32'(d_datain), 32'(ref_mem[7][15:8]));
        tick(); chk("ovf s8 busy", 32'(busy), 0); chk("ovf s8 mem_en", 32'(mem_en), 0);
        tick(); chk("ovf s9 busy", 32'(busy), 0); chk("ovf s9 ovf", 32'(ovf), 1);
        run_op(1, 1, 0, 9'h004, 9'h006, 8'h00, 8'h00, 0, 1, "ovfheld");

        // Reset while the write waits for its high byte: nothing may reach memory.
        @(negedge clk); d_req = 1; d_we = 1; d_addr = 9'h002; d_dataout = 8'h55;
        tick(); chk("rstw busy", 32'(busy), 1);
        #2 rst_n = 0;
        #1 chk_all_zero("rstw async");
        @(negedge clk); d_req = 0; d_dataout = 8'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstw c%0d mem_we", k), 32'(mem_we), 0);
            chk($sformatf("rstw c%0d busy", k), 32'(busy), 0);
        end
        run_op(1, 0, 0, 9'h002, 9'h000, 8'h00, 8'h00, 1, 0, "postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
